smg_display_n: RTL

Parametrised multiplexed seven-segment driver, the next generation of the team's 4-digit display. It converts a binary value to BCD with a sequential double-dabble engine, and supports any digit count, configurable segment/select polarity, per-digit decimal points, optional leading-zero blanking and an overflow indication. It sits between the ADC/measurement datapath and the board's common-anode or common-cathode display pins.

---
 rtl/smg_pkg.sv | 54 +++++
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 rtl/smg_display_n.sv | 118 +++++++++++
 3 files changed

// File: rtl/smg_pkg.sv
// Shared constants, helper functions and the converter state type for the
// multiplexed seven-segment display driver.
package smg_pkg;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // 4*ceil(data_w*log10(2)) + 4, evaluated in fixed point.
    function automatic int bcd_width(input int data_w);
        return 4 * ((data_w * 30103 + 99999) / 100000) + 4;
    endfunction

    // Nibble values 10..15 never come out of a valid BCD digit; show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, then the
// result, decimal points and overflow flag are committed to the live registers.
module bin2bcd_seq
    import smg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BCD_W  = 24,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_W-1:0]     number_data,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [DIGITS-1:0]     disp_dp,
    output logic                  disp_ovf,
    output conv_state_e           state_o
);

    localparam int          CNT_W = $clog2(DATA_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    conv_state_e          state_q, state_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [BCD_W-1:0]     acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0]    dp_pend_q, dp_pend_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0]  disp_bcd_q, disp_bcd_d;
    logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
    logic                 disp_ovf_q, disp_ovf_d;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dp_pend_d  = dp_pend_q;
        ovf_pend_d = ovf_pend_q;
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        disp_ovf_d = disp_ovf_q;

        acc_adj = acc_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d    = number_data;
                    dp_pend_d  = dp_mask;
                    ovf_pend_d = (64'(number_data) >= LIMIT);
                    acc_d      = '0;
                    cnt_d      = CNT_W'(DATA_W);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_bcd_d = acc_q[4*DIGITS-1:0];
                disp_dp_d  = dp_pend_q;
                disp_ovf_d = ovf_pend_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dp_pend_q  <= '0;
            ovf_pend_q <= 1'b0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dp_pend_q  <= dp_pend_d;
            ovf_pend_q <= ovf_pend_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            disp_ovf_q <= disp_ovf_d;
        end
    end

    assign disp_bcd = disp_bcd_q;
    assign disp_dp  = disp_dp_q;
    assign disp_ovf = disp_ovf_q;
    assign state_o  = state_q;

endmodule

// File: rtl/smg_display_n.sv
// Multiplexed N-digit seven-segment driver: binary-to-BCD conversion, digit
// scanning, leading-zero blanking, overflow dashes and pin polarity.
module smg_display_n
    import smg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DATA_W         = 16,
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   number_data,
    input  logic                load,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic                blank_lz,
    output logic [7:0]          row_scan_sig,
    output logic [DIGITS-1:0]   column_scan_sig,
    output logic                busy,
    output logic                overflow
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Widened when DIGITS needs more nibbles than DATA_W can ever fill.
    localparam int ACC_W = (bcd_width(DATA_W) > 4 * DIGITS) ? bcd_width(DATA_W) : 4 * DIGITS;
    localparam logic [7:0]        ROW_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] COL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] disp_bcd;
    logic [DIGITS-1:0]   disp_dp;
    logic                disp_ovf;
    conv_state_e         conv_state;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .BCD_W  (ACC_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .number_data (number_data),
        .dp_mask     (dp_mask),
        .disp_bcd    (disp_bcd),
        .disp_dp     (disp_dp),
        .disp_ovf    (disp_ovf),
        .state_o     (conv_state)
    );

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        row_q, row_d;
    logic [DIGITS-1:0] col_q, col_d;
    logic [6:0]        seg;
    logic              dp;
    logic              upper_nz;
    logic [DIGITS-1:0] col_raw;

    always_comb begin
        presc_d  = presc_q + PRE_W'(1);
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        seg      = SEG_BLANK;
        dp       = 1'b0;
        upper_nz = 1'b0;
        col_raw  = '0;

        if (presc_q == PRE_W'(DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

            // Any non-zero digit at or above the new index keeps it visible.
            for (int j = 0; j < DIGITS; j++) begin
                if (j >= int'(idx_d) && disp_bcd[4*j +: 4] != 4'd0) begin
                    upper_nz = 1'b1;
                end
            end

            if (disp_ovf) begin
                seg = SEG_DASH;
            end else if (blank_lz && idx_d != '0 && !upper_nz) begin
                seg = SEG_BLANK;
            end else begin
                seg = seg_decode(disp_bcd[{idx_d, 2'b00} +: 4]);
                dp  = disp_dp[idx_d];
            end

            col_raw[idx_d] = 1'b1;
            row_d = SEG_ACTIVE_LOW ? ~{dp, seg} : {dp, seg};
            col_d = SEL_ACTIVE_LOW ? ~col_raw : col_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            row_q   <= ROW_OFF;
            col_q   <= COL_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign row_scan_sig    = row_q;
    assign column_scan_sig = col_q;
    assign busy            = (conv_state == SHIFT);
    assign overflow        = disp_ovf;

endmodule
